// File: rtl/seg_scan_driver_param.sv
// Multiplexed N-digit seven-segment scan driver with frame-synchronous shadowing,
// leading-zero blanking and PWM brightness. Optional macro SEG_BLINK_EN adds per-digit blink.
module seg_scan_driver_param #(
    parameter int unsigned N_DIG          = 6,
    parameter int unsigned TIME_SCAN      = 50_000,
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_FRAMES   = 83
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] din,
    input  logic [N_DIG-1:0]   dot_in,
    input  logic               blank_lz,
    input  logic [3:0]         bright,
`ifdef SEG_BLINK_EN
    input  logic [N_DIG-1:0]   blink_mask,
`endif
    output logic [N_DIG-1:0]   sel,
    output logic [7:0]         dig,
    output logic               frame_start
);

    localparam int unsigned     CNT_W     = $clog2(TIME_SCAN);
    localparam int unsigned     IDX_W     = $clog2(N_DIG);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(TIME_SCAN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIG - 1);
    localparam logic [7:0]       SEG_OFF   = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIG-1:0] SEL_OFF   = {N_DIG{SEL_ACTIVE_LOW}};

    if (N_DIG < 2 || N_DIG > 8 || TIME_SCAN < 2 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("seg_scan_driver_param: parameter out of range");
    end

    logic [CNT_W-1:0]   r_cnt_scan;
    logic [IDX_W-1:0]   r_idx;
    logic [3:0]         r_pwm_cnt;
    logic [4*N_DIG-1:0] r_din_sh;
    logic [N_DIG-1:0]   r_dot_sh;
    logic               r_blz_sh;

    logic               w_scan_wrap;
    logic               w_frame_wrap;
    logic [N_DIG-1:0]   w_lz;
    logic               w_zero_run;
    logic [N_DIG-1:0]   w_blink_vec;
    logic [3:0]         w_nib;
    logic               w_dot;
    logic               w_lz_hit;
    logic               w_blink_hit;
    logic [7:0]         w_seg_ah;
    logic [7:0]         w_dig_nxt;
    logic [N_DIG-1:0]   w_sel_nxt;

    // Active-high gfedcba pattern for a hex nibble.
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'h3F;
            4'h1: f_decode = 7'h06;
            4'h2: f_decode = 7'h5B;
            4'h3: f_decode = 7'h4F;
            4'h4: f_decode = 7'h66;
            4'h5: f_decode = 7'h6D;
            4'h6: f_decode = 7'h7D;
            4'h7: f_decode = 7'h07;
            4'h8: f_decode = 7'h7F;
            4'h9: f_decode = 7'h6F;
            4'hA: f_decode = 7'h77;
            4'hB: f_decode = 7'h7C;
            4'hC: f_decode = 7'h39;
            4'hD: f_decode = 7'h5E;
            4'hE: f_decode = 7'h79;
            default: f_decode = 7'h71;
        endcase
    endfunction

    assign w_scan_wrap  = (r_cnt_scan == SCAN_LAST);
    assign w_frame_wrap = w_scan_wrap && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_scan <= '0;
            r_idx      <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (w_scan_wrap) begin
                r_cnt_scan <= '0;
                r_idx      <= w_frame_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt_scan <= r_cnt_scan + CNT_W'(1);
            end
        end
    end

    // Display data is only captured on the frame boundary so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_sh <= '0;
            r_dot_sh <= '0;
            r_blz_sh <= 1'b0;
        end else if (w_frame_wrap) begin
            r_din_sh <= din;
            r_dot_sh <= dot_in;
            r_blz_sh <= blank_lz;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [N_DIG-1:0] r_blink_mask_sh;
    logic [FRM_W-1:0] r_frm_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_mask_sh <= '0;
            r_frm_cnt       <= '0;
            r_blink_phase   <= 1'b0;
        end else if (w_frame_wrap) begin
            r_blink_mask_sh <= blink_mask;
            if (r_frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                r_frm_cnt     <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frm_cnt <= r_frm_cnt + FRM_W'(1);
            end
        end
    end

    assign w_blink_vec = r_blink_phase ? r_blink_mask_sh : '0;
`else
    assign w_blink_vec = '0;
`endif

    // A digit is blanked while it and every more-significant digit are zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz       = '0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run && (r_din_sh[4*i +: 4] == 4'h0);
            w_lz[i]    = r_blz_sh && w_zero_run;
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_dot       = 1'b0;
        w_lz_hit    = 1'b0;
        w_blink_hit = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib       = r_din_sh[4*i +: 4];
                w_dot       = r_dot_sh[i];
                w_lz_hit    = w_lz[i];
                w_blink_hit = w_blink_vec[i];
            end
        end
    end

    always_comb begin
        w_seg_ah = {w_dot, (w_lz_hit ? 7'h00 : f_decode(w_nib))};
        if ((r_pwm_cnt > bright) || w_blink_hit) begin
            w_seg_ah = 8'h00;
        end
        w_dig_nxt = SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
        w_sel_nxt = N_DIG'(1) << r_idx;
        if (SEL_ACTIVE_LOW) begin
            w_sel_nxt = ~w_sel_nxt;
        end
    end

    // Select and segments share one register stage so they switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= SEL_OFF;
            dig         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            sel         <= w_sel_nxt;
            dig         <= w_dig_nxt;
            frame_start <= w_frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver_param.sv
// Directed bench for seg_scan_driver_param with N_DIG=4, TIME_SCAN=4, active-low outputs.
module tb_seg_scan_driver_param;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  dot_in;
    logic        blank_lz;
    logic [3:0]  bright;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [3:0]  sel;
    logic [7:0]  dig;
    logic        frame_start;

    int checks;
    int failures;
    int k;

    seg_scan_driver_param #(
        .N_DIG(4), .TIME_SCAN(4), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .dot_in(dot_in),
        .blank_lz(blank_lz),
        .bright(bright),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .sel(sel),
        .dig(dig),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        k = 0;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    // Expected active-low select for the sample taken k cycles after reset release.
    function automatic logic [3:0] exp_sel(input int kk);
        logic [3:0] oh;
        oh = 4'b0001 << (((kk - 1) / 4) % 4);
        return ~oh;
    endfunction

    task automatic test_reset();
        din = 16'h0000; dot_in = 4'h0; blank_lz = 1'b0; bright = 4'd15;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sel !== 4'b1111 || dig !== 8'hFF || frame_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d sel=%b dig=%h fs=%b exp sel=1111 dig=FF fs=0", i, sel, dig, frame_start);
            end
        end
        rst = 1'b0;
        k = 0;
        tick();
        checks++;
        if (sel !== 4'b1110) begin
            failures++;
            $display("FAIL reset_first_sel got=%b exp=1110", sel);
        end
        while (k < 15) begin
            checks++;
            if (frame_start !== 1'b0) begin
                failures++;
                $display("FAIL reset_fs_early k=%0d got=%b exp=0", k, frame_start);
            end
            tick();
        end
        tick();
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL reset_fs_first_wrap k=%0d got=%b exp=1", k, frame_start);
        end
        tick();
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_fs_single k=%0d got=%b exp=0", k, frame_start);
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'hF9; exp_d[1] = 8'hA4; exp_d[2] = 8'h30; exp_d[3] = 8'h99;
        din = 16'h4321; dot_in = 4'b0100; blank_lz = 1'b0; bright = 4'd15;
        do_reset();
        tick();
        checks++;
        if (dig !== 8'hC0) begin
            failures++;
            $display("FAIL scan_first_frame_zero got=%h exp=C0", dig);
        end
        run_to(16);
        while (k < 32) begin
            tick();
            checks++;
            if (sel !== exp_sel(k) || dig !== exp_d[(k - 17) / 4]) begin
                failures++;
                $display("FAIL scan_order k=%0d sel=%b dig=%h exp sel=%b dig=%h", k, sel, dig, exp_sel(k), exp_d[(k - 17) / 4]);
            end
        end
    endtask

    task automatic test_reset_abort();
        run_to(38);
        rst = 1'b1;
        tick();
        checks++;
        if (sel !== 4'b1111 || dig !== 8'hFF || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL abort_outputs sel=%b dig=%h fs=%b exp sel=1111 dig=FF fs=0", sel, dig, frame_start);
        end
        tick();
        rst = 1'b0;
        k = 0;
        tick();
        checks++;
        if (sel !== 4'b1110 || dig !== 8'hC0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart sel=%b dig=%h fs=%b exp sel=1110 dig=C0 fs=0", sel, dig, frame_start);
        end
    endtask

    task automatic test_tear_free();
        int fs_cnt;
        din = 16'h1111; dot_in = 4'h0; blank_lz = 1'b0; bright = 4'd15;
        do_reset();
        run_to(16);
        fs_cnt = 0;
        while (k < 32) begin
            tick();
            if (k == 20) din = 16'h2222;
            fs_cnt += int'(frame_start);
            checks++;
            if (dig !== 8'hF9) begin
                failures++;
                $display("FAIL tear_old_frame k=%0d got=%h exp=F9", k, dig);
            end
        end
        checks++;
        if (fs_cnt != 1) begin
            failures++;
            $display("FAIL tear_fs_count got=%0d exp=1", fs_cnt);
        end
        while (k < 48) begin
            tick();
            checks++;
            if (dig !== 8'hA4) begin
                failures++;
                $display("FAIL tear_new_frame k=%0d got=%h exp=A4", k, dig);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a[0] = 8'hC0; exp_a[1] = 8'h92; exp_a[2] = 8'hFF; exp_a[3] = 8'hFF;
        exp_b[0] = 8'hC0; exp_b[1] = 8'hFF; exp_b[2] = 8'hFF; exp_b[3] = 8'h7F;
        din = 16'h0050; dot_in = 4'h0; blank_lz = 1'b1; bright = 4'd15;
        do_reset();
        run_to(16);
        while (k < 32) begin
            tick();
            if (k == 20) begin
                din = 16'h0000;
                dot_in = 4'b1000;
            end
            checks++;
            if (dig !== exp_a[(k - 17) / 4]) begin
                failures++;
                $display("FAIL blank_0050 k=%0d got=%h exp=%h", k, dig, exp_a[(k - 17) / 4]);
            end
        end
        while (k < 48) begin
            tick();
            checks++;
            if (dig !== exp_b[(k - 33) / 4]) begin
                failures++;
                $display("FAIL blank_0000 k=%0d got=%h exp=%h", k, dig, exp_b[(k - 33) / 4]);
            end
        end
    endtask

    task automatic test_brightness();
        int on_cnt;
        logic [7:0] exp_dig;
        din = 16'h8888; dot_in = 4'h0; blank_lz = 1'b0; bright = 4'd3;
        do_reset();
        run_to(16);
        on_cnt = 0;
        while (k < 32) begin
            tick();
            exp_dig = (((k - 1) % 16) <= 3) ? 8'h80 : 8'hFF;
            if (dig === 8'h80) on_cnt++;
            checks++;
            if (dig !== exp_dig || sel !== exp_sel(k)) begin
                failures++;
                $display("FAIL bright_pwm k=%0d dig=%h sel=%b exp dig=%h sel=%b", k, dig, sel, exp_dig, exp_sel(k));
            end
        end
        checks++;
        if (on_cnt != 4) begin
            failures++;
            $display("FAIL bright_duty got=%0d exp=4", on_cnt);
        end
        bright = 4'd15;
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        logic [7:0] exp_dig;
        din = 16'h0007; dot_in = 4'h0; blank_lz = 1'b0; bright = 4'd15; blink_mask = 4'b0001;
        do_reset();
        run_to(16);
        for (int f = 1; f < 8; f++) begin
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    tick();
                    if (c == 0) begin
                        if (s == 0) exp_dig = (((f / 2) % 2) == 0) ? 8'hF8 : 8'hFF;
                        else        exp_dig = 8'hC0;
                        checks++;
                        if (dig !== exp_dig) begin
                            failures++;
                            $display("FAIL blink frame=%0d slot=%0d got=%h exp=%h", f, s, dig, exp_dig);
                        end
                    end
                end
            end
        end
        blink_mask = 4'b0000;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        k = 0;
        rst = 1'b1;
        din = 16'h0000; dot_in = 4'h0; blank_lz = 1'b0; bright = 4'd15;
`ifdef SEG_BLINK_EN
        blink_mask = 4'b0000;
`endif
        test_reset();
        test_scan_order();
        test_reset_abort();
        test_tear_free();
        test_blanking();
        test_brightness();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
